vco_sweep_controller: RTL
=========================

VCO_SWEEP_CONTROLLER -- requirements
Module: vco_sweep_controller

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, audio sample strobe frequency in Hz; SAMPLE_RATE < CLOCK_RATE.
REQ-003 SHALL have parameter DEPTH, default 8, number of level-table entries; power of two.
REQ-004 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  level-table write strobe.
REQ-007 SHALL have port wr_addr  input  log2(DEPTH)  level-table write index.
REQ-008 SHALL have port wr_data  input  16 signed  level value to write.
REQ-009 SHALL have port hold_samples  input  16 unsigned  samples per step; sampled on accepted start.
REQ-010 SHALL have port start  input  1  begin sweep (single-cycle pulse).
REQ-011 SHALL have port stop  input  1  abort sweep.
REQ-012 SHALL have port loop  input  1  repeat table; sampled on accepted start.
REQ-013 SHALL have port audio_clk_en  output  1  one-cycle sample strobe for the VCO.
REQ-014 SHALL have port v_control  output  16 signed  control voltage to the VCO.
REQ-015 SHALL have port step_idx  output  log2(DEPTH)  table index currently driven.
REQ-016 SHALL have port busy  output  1  high in ARM and RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse on non-looping completion.

Function
REQ-018 SHALL run a strobe accumulator every cycle, independent of the FSM: if acc+SAMPLE_RATE >= CLOCK_RATE then acc <= acc+SAMPLE_RATE-CLOCK_RATE and audio_clk_en <= 1, else acc <= acc+SAMPLE_RATE and audio_clk_en <= 0.
REQ-019 SHALL size acc to hold CLOCK_RATE+SAMPLE_RATE without overflow; exactly SAMPLE_RATE strobes per CLOCK_RATE cycles; spacing floor or ceil of CLOCK_RATE/SAMPLE_RATE.
REQ-020 SHALL write wr_data into table[wr_addr] on the clock edge where wr_en=1, in any state.
REQ-021 SHALL implement FSM states IDLE, ARM and RUN.
REQ-022 SHALL, in IDLE, on start=1 and stop=0: latch hold_samples (0 treated as 1) and loop, then go to ARM; busy rises the next cycle.
REQ-023 SHALL, in ARM, on audio_clk_en=1: load v_control <= table[0], step_idx <= 0, hold_cnt <= latched hold, and go to RUN.
REQ-024 SHALL, in RUN, decrement hold_cnt on each audio_clk_en; on the strobe where hold_cnt==1, advance the step.
REQ-025 SHALL, on advance with step_idx < DEPTH-1, load table[step_idx+1] and reload hold_cnt.
REQ-026 SHALL, on advance with step_idx == DEPTH-1 and loop latched, wrap to index 0, load table[0] and stay in RUN.
REQ-027 SHALL, on advance with step_idx == DEPTH-1 and loop not latched, go to IDLE, pulse done for one cycle and hold v_control and step_idx.
REQ-028 SHALL, when a load and a write target the same index in one cycle, load wr_data (write-through).
REQ-029 SHALL change v_control only on loads, on stop or on reset; table writes never alter v_control directly.
REQ-030 SHALL, on stop=1 in ARM or RUN, go to IDLE next edge with v_control <= 0, step_idx <= 0 and no done pulse.
REQ-031 SHALL give stop priority over start in the same cycle; stop in IDLE has no effect.
REQ-032 SHALL ignore start while busy=1.

Reset
REQ-033 SHALL, on reset_n=0 and asynchronously: clear acc and all table entries, force state to IDLE, and drive audio_clk_en, v_control, step_idx, busy and done to 0.
REQ-034 SHALL, when reset is asserted mid-sweep, abort the sweep with no done pulse; the first strobe after release follows REQ-018 from acc=0 (cycle 21 for defaults).

Verification
REQ-035 SHALL cover strobe rate: defaults, 1000000 cycles after reset -> exactly 48000 strobes, first on cycle 21, all gaps 20 or 21.
REQ-036 SHALL cover a single sweep: table {32767,30000,25000,20000,15000,10000,5000,2500}, hold=3, loop=0, start -> each value held 3 strobes; done pulses after strobe 24 from ARM exit; busy=0; v_control stays 2500; step_idx=7.
REQ-037 SHALL cover loop and stop: same table, loop=1 -> after 2500 the next value is 32767 with busy=1; then stop -> next cycle v_control=0, busy=0, done never asserted.
REQ-038 SHALL cover hold=0: behaves as hold=1, with v_control changing on every strobe.
REQ-039 SHALL cover collisions: start+stop same cycle in IDLE -> stays IDLE; write of -1000 to index 1 on the load cycle of index 1 -> v_control=-1000.
REQ-040 SHALL cover reset mid-RUN: assert reset_n=0 -> outputs 0 immediately and table reads 0 afterwards.

Source files
------------

// File: rtl/vco_sweep_controller.sv
// Steps a VCO control voltage through a small level table, holding each
// level for a programmable number of audio sample strobes. The strobe is a
// fractional-rate pulse derived from the system clock by an accumulator.
module vco_sweep_controller #(
    parameter int CLOCK_RATE  = 1000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic signed [15:0]         wr_data,
    input  logic [15:0]                hold_samples,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop,
    output logic                       audio_clk_en,
    output logic signed [15:0]         v_control,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ACC_W = $clog2(CLOCK_RATE + SAMPLE_RATE + 1);
    localparam logic [ACC_W-1:0] SR   = ACC_W'(SAMPLE_RATE);
    localparam logic [ACC_W-1:0] CR   = ACC_W'(CLOCK_RATE);
    localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_sum;
    logic               strobe_q;
    logic signed [15:0] level_q [DEPTH];

    state_t             state_q, state_d;
    logic signed [15:0] v_q, v_d;
    logic [AW-1:0]      step_q, step_d;
    logic [15:0]        hold_lat_q, hold_lat_d;
    logic               loop_q, loop_d;
    logic [15:0]        hold_cnt_q, hold_cnt_d;
    logic               done_q, done_d;

    // Index that would be loaded on this cycle, and its value with a
    // same-cycle table write forwarded through.
    logic [AW-1:0]      load_idx;
    logic signed [15:0] load_val;

    assign acc_sum  = acc_q + SR;
    assign load_idx = (state_q == RUN && step_q != LAST) ? step_q + 1'b1 : '0;
    assign load_val = (wr_en && wr_addr == load_idx) ? wr_data : level_q[load_idx];

    // Free-running fractional strobe: SAMPLE_RATE pulses per CLOCK_RATE cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else if (acc_sum >= CR) begin
            acc_q    <= acc_sum - CR;
            strobe_q <= 1'b1;
        end else begin
            acc_q    <= acc_sum;
            strobe_q <= 1'b0;
        end
    end

    // Level table, writable in any state, cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                level_q[i] <= '0;
            end
        end else if (wr_en) begin
            level_q[wr_addr] <= wr_data;
        end
    end

    // Sweep sequencer next-state and output logic
    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        step_d     = step_q;
        hold_lat_d = hold_lat_q;
        loop_d     = loop_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    // A hold of zero would never expire; run it as one strobe
                    hold_lat_d = (hold_samples == 16'd0) ? 16'd1 : hold_samples;
                    loop_d     = loop;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (stop) begin
                    state_d = IDLE;
                    v_d     = '0;
                    step_d  = '0;
                end else if (strobe_q) begin
                    v_d        = load_val;
                    step_d     = load_idx;
                    hold_cnt_d = hold_lat_q;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    v_d     = '0;
                    step_d  = '0;
                end else if (strobe_q) begin
                    if (hold_cnt_q == 16'd1) begin
                        if (step_q != LAST || loop_q) begin
                            v_d        = load_val;
                            step_d     = load_idx;
                            hold_cnt_d = hold_lat_q;
                        end else begin
                            // Last level stays on the output after completion
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q - 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sweep sequencer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            v_q        <= '0;
            step_q     <= '0;
            hold_lat_q <= '0;
            loop_q     <= 1'b0;
            hold_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            step_q     <= step_d;
            hold_lat_q <= hold_lat_d;
            loop_q     <= loop_d;
            hold_cnt_q <= hold_cnt_d;
            done_q     <= done_d;
        end
    end

    assign audio_clk_en = strobe_q;
    assign v_control    = v_q;
    assign step_idx     = step_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

endmodule
